decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage between fetch and execute.
- Classifies each instruction, extracts register/immediate/target fields and resolves source/destination registers (including implicit r30/r31).
- Adds what a combinational decoder cannot: valid/ready handshake, load-use and mul/div-busy stall detection, flush, illegal-opcode flagging and a stall counter.

Parameters:
- INSN_W, 32, instruction width; field positions are taken from the MSB down.
- REG_AW, 5, register-index width (2**REG_AW registers).
- OPC_W, 5, opcode width, at instruction[INSN_W-1 -: OPC_W].
- ALUOP_W, 5, ALU-op width, at instruction[6 -: ALUOP_W].
- IMM_W, 17, I-type immediate width (low bits); sign-extended to INSN_W.
- TGT_W, 27, JI-type target width (low bits); zero-extended to INSN_W.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_insn  in  INSN_W  instruction word
- in_pc  in  INSN_W  PC of in_insn
- in_ready  out  1  stage accepts in_insn this cycle
- flush  in  1  kill the held and incoming instruction (branch taken)
- md_busy  in  1  multiply/divide unit occupied
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  INSN_W  registered PC
- out_class  out  16  one-hot: add, sub, mul, div, other_alu, addi, sw, lw, j, bne, jal, jr, blt, bex, setx, illegal (bit 0..15)
- out_type  out  2  0=R, 1=I, 2=JI, 3=JII
- out_alu_op  out  ALUOP_W  ALU-op field
- out_src_a, out_src_b  out  REG_AW  source registers
- out_rd  out  REG_AW  destination register
- out_rd_we  out  1  destination write enable
- out_imm  out  INSN_W  sign-extended immediate
- out_tgt  out  INSN_W  zero-extended target
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, reset_n=0): out_valid=0; all other out_* = 0; stall_count=0. Outputs stay at these values until the first accepted instruction.
- Field extraction: Rd=[26:22], Rs=[21:17], Rt=[16:12] (generalised to REG_AW bits from below the opcode).
- Opcodes: 0 alu, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw, 21 setx, 22 bex.
  - ALU ops: add=0, sub=1, mul=6, div=7; any other ALU op sets other_alu.
  - Any other opcode sets illegal, with out_rd_we=0.
- Type: jr->3; j/jal/bex/setx->2; sw/lw/bne/blt->1; everything else->0.
- Source registers:
  - src_a: Rs for R/addi/lw/sw; Rd for bne/blt/jr; 30 for bex; 0 otherwise.
  - src_b: Rt for R; Rd for sw; Rs for bne/blt; 0 otherwise.
- Destination:
  - out_rd = Rd for R/addi/lw; 31 for jal; 30 for setx; 0 otherwise.
  - out_rd_we = 1 for those classes, but forced to 0 when out_rd==0.
- Advance: adv = !out_valid | out_ready.
- Hazard (combinational on inputs and the held bundle), hz = in_valid & (lu | md):
  - lu (load-use): out_valid & out lw & out_rd_we & (out_rd == decoded src_a or src_b of in_insn) & that source is actually read.
  - md: incoming mul/div & md_busy.
- in_ready = adv & !hz & !flush.
- Accept (in_valid & in_ready): the bundle is registered on the next edge with out_valid=1. Latency is 1 cycle.
- Hazard or flush with adv: out_valid<=0 (a bubble is inserted); in_insn is held by fetch.
- !adv: all out_* hold and must be stable while out_valid & !out_ready.
- Flush takes priority over everything: out_valid<=0 next edge and no accept that cycle, even if out_ready=0.
- stall_count: +1 each cycle with hz & !flush; saturates at all-ones and never wraps.
- Simultaneous cases:
  - Load-use and md hazard together count once.
  - A flush on a hazard cycle does not count.
- Reset asserted mid-stream drops the held bundle immediately (async clear).

Decomposition:
- Shared package decode_pkg holds:
  - opcode and ALU-op localparams;
  - out_class bit indices;
  - type encodings;
  - implicit register constants REG_RSTATUS=30, REG_RA=31.
- One combinational sub-module, insn_fields, does pure extraction/classification: insn -> class, type, src_a/b, rd, rd_we, imm, tgt.
- decode_stage owns the handshake, hazard logic, pipeline register and counter.

Test Plan:
- Reset, then in_insn=addi r3,r1,-5 (0x28C3FFFB), out_ready=1 -> one cycle later out_valid=1, class addi, type 1, src_a=1, rd=3, rd_we=1, out_imm=0xFFFFFFFB.
- lw r4,0(r2) followed by add r5,r4,r6 -> add held one cycle with in_ready=0; bubble (out_valid=0); add issues next cycle; stall_count=1.
- mul r7,r1,r2 with md_busy=1 for 3 cycles -> in_ready=0 for 3 cycles; stall_count=3; issues on the cycle after md_busy falls.
- out_ready=0 for 4 cycles while holding jal 0x100 -> all outputs stable; rd=31, type 2, out_tgt=0x100.
- flush while holding bne and presenting setx -> out_valid=0 next cycle; setx not accepted that cycle; stall_count unchanged.
- opcode 12 -> class illegal (bit 15), rd_we=0. Separately, add r0,r1,r2 -> rd_we=0. Separately, reset_n low mid-transfer -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU ops, class bit positions,
// instruction formats and implicit register numbers.
package decode_pkg;

  localparam int OPC_ALU  = 0;
  localparam int OPC_J    = 1;
  localparam int OPC_BNE  = 2;
  localparam int OPC_JAL  = 3;
  localparam int OPC_JR   = 4;
  localparam int OPC_ADDI = 5;
  localparam int OPC_BLT  = 6;
  localparam int OPC_SW   = 7;
  localparam int OPC_LW   = 8;
  localparam int OPC_SETX = 21;
  localparam int OPC_BEX  = 22;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 6;
  localparam int ALU_DIV = 7;

  // One-hot positions inside out_class
  localparam int CLS_ADD       = 0;
  localparam int CLS_SUB       = 1;
  localparam int CLS_MUL       = 2;
  localparam int CLS_DIV       = 3;
  localparam int CLS_OTHER_ALU = 4;
  localparam int CLS_ADDI      = 5;
  localparam int CLS_SW        = 6;
  localparam int CLS_LW        = 7;
  localparam int CLS_J         = 8;
  localparam int CLS_BNE       = 9;
  localparam int CLS_JAL       = 10;
  localparam int CLS_JR        = 11;
  localparam int CLS_BLT       = 12;
  localparam int CLS_BEX       = 13;
  localparam int CLS_SETX      = 14;
  localparam int CLS_ILLEGAL   = 15;
  localparam int CLS_W         = 16;

  typedef enum logic [1:0] {
    TYPE_R   = 2'd0,
    TYPE_I   = 2'd1,
    TYPE_JI  = 2'd2,
    TYPE_JII = 2'd3
  } insn_type_e;

  localparam int REG_RSTATUS = 30;
  localparam int REG_RA      = 31;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle of the decode stage.
interface decode_stage_if #(
  parameter int INSN_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 5
);
  logic               in_valid;
  logic [INSN_W-1:0]  in_insn;
  logic [INSN_W-1:0]  in_pc;
  logic               in_ready;

  logic               out_valid;
  logic               out_ready;
  logic [INSN_W-1:0]  out_pc;
  logic [15:0]        out_class;
  logic [1:0]         out_type;
  logic [ALUOP_W-1:0] out_alu_op;
  logic [REG_AW-1:0]  out_src_a;
  logic [REG_AW-1:0]  out_src_b;
  logic [REG_AW-1:0]  out_rd;
  logic               out_rd_we;
  logic [INSN_W-1:0]  out_imm;
  logic [INSN_W-1:0]  out_tgt;

  // The stage itself
  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_type, out_alu_op,
           out_src_a, out_src_b, out_rd, out_rd_we, out_imm, out_tgt
  );

  // Fetch and execute around it
  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_type, out_alu_op,
           out_src_a, out_src_b, out_rd, out_rd_we, out_imm, out_tgt
  );
endinterface

// File: rtl/decode_stage_insn_fields.sv
// Pure combinational decode of one instruction word: class, format, register
// operands (including implicit r30/r31), immediate and jump target.
module insn_fields
  import decode_pkg::*;
#(
  parameter int INSN_W  = 32,
  parameter int REG_AW  = 5,
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 5,
  parameter int IMM_W   = 17,
  parameter int TGT_W   = 27
) (
  input  logic [INSN_W-1:0]  insn,
  output logic [CLS_W-1:0]   cls,
  output insn_type_e         typ,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [REG_AW-1:0]  src_a,
  output logic [REG_AW-1:0]  src_b,
  output logic               src_a_re,
  output logic               src_b_re,
  output logic [REG_AW-1:0]  rd,
  output logic               rd_we,
  output logic [INSN_W-1:0]  imm,
  output logic [INSN_W-1:0]  tgt
);
  localparam int RD_LSB = INSN_W - OPC_W - REG_AW;
  localparam int RS_LSB = RD_LSB - REG_AW;
  localparam int RT_LSB = RS_LSB - REG_AW;

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] f_rd, f_rs, f_rt;
  logic              wr;

  assign opc    = insn[INSN_W-1 -: OPC_W];
  assign f_rd   = insn[RD_LSB +: REG_AW];
  assign f_rs   = insn[RS_LSB +: REG_AW];
  assign f_rt   = insn[RT_LSB +: REG_AW];
  assign alu_op = insn[6 -: ALUOP_W];
  assign imm    = {{(INSN_W-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
  assign tgt    = {{(INSN_W-TGT_W){1'b0}}, insn[TGT_W-1:0]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    cls      = '0;
    typ      = TYPE_R;
    src_a    = '0;
    src_b    = '0;
    src_a_re = 1'b0;
    src_b_re = 1'b0;
    rd       = '0;
    wr       = 1'b0;
    case (int'(opc))
      OPC_ALU: begin
        case (int'(alu_op))
          ALU_ADD: cls[CLS_ADD]       = 1'b1;
          ALU_SUB: cls[CLS_SUB]       = 1'b1;
          ALU_MUL: cls[CLS_MUL]       = 1'b1;
          ALU_DIV: cls[CLS_DIV]       = 1'b1;
          default: cls[CLS_OTHER_ALU] = 1'b1;
        endcase
        src_a = f_rs; src_a_re = 1'b1;
        src_b = f_rt; src_b_re = 1'b1;
        rd    = f_rd; wr       = 1'b1;
      end
      OPC_ADDI: begin
        cls[CLS_ADDI] = 1'b1; typ = TYPE_I;
        src_a = f_rs; src_a_re = 1'b1;
        rd    = f_rd; wr       = 1'b1;
      end
      OPC_LW: begin
        cls[CLS_LW] = 1'b1; typ = TYPE_I;
        src_a = f_rs; src_a_re = 1'b1;
        rd    = f_rd; wr       = 1'b1;
      end
      OPC_SW: begin
        cls[CLS_SW] = 1'b1; typ = TYPE_I;
        src_a = f_rs; src_a_re = 1'b1;
        src_b = f_rd; src_b_re = 1'b1;
      end
      OPC_BNE: begin
        cls[CLS_BNE] = 1'b1; typ = TYPE_I;
        src_a = f_rd; src_a_re = 1'b1;
        src_b = f_rs; src_b_re = 1'b1;
      end
      OPC_BLT: begin
        cls[CLS_BLT] = 1'b1; typ = TYPE_I;
        src_a = f_rd; src_a_re = 1'b1;
        src_b = f_rs; src_b_re = 1'b1;
      end
      OPC_JR: begin
        cls[CLS_JR] = 1'b1; typ = TYPE_JII;
        src_a = f_rd; src_a_re = 1'b1;
      end
      OPC_J: begin
        cls[CLS_J] = 1'b1; typ = TYPE_JI;
      end
      OPC_JAL: begin
        cls[CLS_JAL] = 1'b1; typ = TYPE_JI;
        rd = REG_AW'(REG_RA); wr = 1'b1;
      end
      OPC_BEX: begin
        cls[CLS_BEX] = 1'b1; typ = TYPE_JI;
        src_a = REG_AW'(REG_RSTATUS); src_a_re = 1'b1;
      end
      OPC_SETX: begin
        cls[CLS_SETX] = 1'b1; typ = TYPE_JI;
        rd = REG_AW'(REG_RSTATUS); wr = 1'b1;
      end
      default: cls[CLS_ILLEGAL] = 1'b1;
    endcase
    // r0 is hard-wired, so a write to it is never a real write
    rd_we = wr && (rd != '0);
  end
endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use and mul/div-busy
// stall detection, flush, and a saturating hazard-stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSN_W      = 32,
  parameter int REG_AW      = 5,
  parameter int OPC_W       = 5,
  parameter int ALUOP_W     = 5,
  parameter int IMM_W       = 17,
  parameter int TGT_W       = 27,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   md_busy,
  decode_stage_if.slave          bus,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic [CLS_W-1:0]   cls;
  insn_type_e         typ;
  logic [ALUOP_W-1:0] alu_op;
  logic [REG_AW-1:0]  src_a, src_b, rd;
  logic               src_a_re, src_b_re, rd_we;
  logic [INSN_W-1:0]  imm, tgt;
  logic               adv, lu, md, hz, accept;

  insn_fields #(
    .INSN_W(INSN_W), .REG_AW(REG_AW), .OPC_W(OPC_W),
    .ALUOP_W(ALUOP_W), .IMM_W(IMM_W), .TGT_W(TGT_W)
  ) u_fields (
    .insn(bus.in_insn), .cls(cls), .typ(typ), .alu_op(alu_op),
    .src_a(src_a), .src_b(src_b), .src_a_re(src_a_re), .src_b_re(src_b_re),
    .rd(rd), .rd_we(rd_we), .imm(imm), .tgt(tgt)
  );

  assign adv = !bus.out_valid || bus.out_ready;

  // The held lw's data is not available until after execute, so a reader right behind it waits.
  assign lu = bus.out_valid && bus.out_class[CLS_LW] && bus.out_rd_we &&
              ((src_a_re && (bus.out_rd == src_a)) || (src_b_re && (bus.out_rd == src_b)));
  assign md = (cls[CLS_MUL] || cls[CLS_DIV]) && md_busy;
  assign hz = bus.in_valid && (lu || md);

  assign bus.in_ready = adv && !hz && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_pc     <= '0;
      bus.out_class  <= '0;
      bus.out_type   <= '0;
      bus.out_alu_op <= '0;
      bus.out_src_a  <= '0;
      bus.out_src_b  <= '0;
      bus.out_rd     <= '0;
      bus.out_rd_we  <= 1'b0;
      bus.out_imm    <= '0;
      bus.out_tgt    <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_pc     <= bus.in_pc;
        bus.out_class  <= cls;
        bus.out_type   <= typ;
        bus.out_alu_op <= alu_op;
        bus.out_src_a  <= src_a;
        bus.out_src_b  <= src_b;
        bus.out_rd     <= rd;
        bus.out_rd_we  <= rd_we;
        bus.out_imm    <= imm;
        bus.out_tgt    <= tgt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (hz && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
endmodule
